// File: rtl/mem_rd_pkg.sv
// Shared constants, FSM state type and memory rdwr encodings for the burst reader.
package mem_rd_pkg;

  localparam int MEM_DEPTH = 4096;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int DATA_W    = 16;
  localparam int LEN_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  function automatic logic rdwr_code(input logic is_write);
    return is_write ? WR : RD;
  endfunction

endpackage

// File: rtl/mem_rd_fifo2.sv
// Two-entry synchronous FIFO that buffers read data between the memory and the consumer.
module mem_rd_fifo2 #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] slots [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word in the same cycle its head leaves.
  assign do_push = push && (!full || do_pop);
  assign dout    = slots[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator for the 4096 x 16 synchronous memory, streaming words over valid/ready.
// Optional MEM_BURST_READER_CHECKSUM_EN adds a running sum of accepted words on port checksum.
module mem_burst_reader #(
  parameter int ADDR_W = mem_rd_pkg::ADDR_W,
  parameter int DATA_W = mem_rd_pkg::DATA_W,
  parameter int LEN_W  = mem_rd_pkg::LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_rdwr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MEM_BURST_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  import mem_rd_pkg::*;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  accepted;
  logic              inflight;
  logic              hs;
  logic              last_hs;
  logic              accept_start;
  logic [2:0]        occupancy;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  assign hs           = out_valid && out_ready;
  assign accept_start = (state == IDLE) && start;
  assign last_hs      = hs && (accepted == len_q - LEN_W'(1));
  // A slot freed by this cycle's handshake counts as free, which keeps one word per cycle.
  assign occupancy    = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, hs};

  assign mem_datain = '0;
  assign mem_rdwr   = rdwr_code(1'b0);
  assign mem_addr   = mem_en ? (base_q + issued[ADDR_W-1:0]) : '0;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_dout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        mem_en = (issued < len_q) && (occupancy < 3'd2);
        if (last_hs) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_en;
      if (accept_start) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (mem_en) begin
          issued <= issued + LEN_W'(1);
        end
        if (hs) begin
          accepted <= accepted + LEN_W'(1);
        end
      end
    end
  end

  mem_rd_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (inflight && (!fifo_full || hs)),
    .pop    (hs),
    .din    (mem_dataout),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef MEM_BURST_READER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (accept_start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed scoreboard bench for mem_burst_reader with a registered-read memory model.
// Checksum checks are compiled only when MEM_BURST_READER_CHECKSUM_EN is defined.
module tb_mem_burst_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        busy;
  logic        done;
  logic [11:0] mem_addr;
  logic [15:0] mem_datain;
  logic        mem_rdwr;
  logic        mem_en;
  logic [15:0] mem_dataout = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef MEM_BURST_READER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] cs_at_done = '0;
`endif

  logic [15:0] mem [4096];
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int en_count = 0;
  int hs_count = 0;
  int outstanding = 0;
  int first_hs_cyc = 0;
  int last_hs_cyc = 0;
  bit seen_first_hs = 1'b0;

  mem_burst_reader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_rdwr   (mem_rdwr),
    .mem_en     (mem_en),
    .mem_dataout(mem_dataout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef MEM_BURST_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (mem_en && !mem_rdwr) mem_dataout <= mem[mem_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Interface monitor: addresses, credit limit and streamed words against the scoreboard.
  always @(negedge clock) begin
    logic [31:0] e;
    int hs_i;
    if (!reset_n) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
    end else begin
      hs_i = (out_valid && out_ready) ? 1 : 0;
      if (mem_en) begin
        en_count++;
        check_output("credit_limit", {31'b0, (outstanding - hs_i) < 2}, 32'd1);
        e = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
        check_output("mem_addr", 32'(mem_addr), e);
      end
      if (hs_i == 1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_output("out_data", 32'(out_data), e);
        hs_count++;
        if (!seen_first_hs) first_hs_cyc = cyc;
        seen_first_hs = 1'b1;
        last_hs_cyc = cyc;
      end
      outstanding = outstanding + (mem_en ? 1 : 0) - hs_i;
    end
  end

  task automatic apply_stimulus(input logic [11:0] base, input logic [12:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      addr_q.push_back(32'(a));
      exp_q.push_back(32'(mem[a]));
    end
    en_count = 0;
    seen_first_hs = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    base_addr = base;
    length = len;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit random_ready, input int exp_len, input bit check_rate);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
`ifdef MEM_BURST_READER_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end else begin
        @(posedge clock);
        #1;
        if (random_ready) out_ready = 1'($urandom_range(0, 1));
      end
    end
    check_output("done_seen", {31'b0, seen}, 32'd1);
    check_output("done_after_last_hs", 32'(cyc), 32'(last_hs_cyc + 1));
    check_output("words_left", 32'(exp_q.size()), 32'd0);
    check_output("mem_en_cycles", 32'(en_count), 32'(exp_len));
    check_output("busy_at_done", {31'b0, busy}, 32'd0);
    if (check_rate) check_output("one_word_per_cycle", 32'(last_hs_cyc - first_hs_cyc), 32'(exp_len - 1));
    @(negedge clock);
    check_output("done_one_cycle", {31'b0, done}, 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs_base;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3) ^ 16'h3C00;
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA000 + 16'(i);
    mem[12'h400] = 16'hFFFF;
    mem[12'h401] = 16'h0002;
    mem[12'h402] = 16'h1234;

    #2;
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_mem_en", {31'b0, mem_en}, 32'd0);
    check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Burst 1: latency and full-rate streaming
    apply_stimulus(12'h010, 13'd4);
    check_output("first_mem_en", {31'b0, mem_en}, 32'd1);
    check_output("first_mem_addr", 32'(mem_addr), 32'h010);
    check_output("mem_rdwr_read", {31'b0, mem_rdwr}, 32'd0);
    check_output("mem_datain_zero", 32'(mem_datain), 32'd0);
    check_output("busy_running", {31'b0, busy}, 32'd1);
    check_output("valid_e0", {31'b0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
    check_output("valid_e1", {31'b0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
    check_output("valid_e2", {31'b0, out_valid}, 32'd1);
    check_output("first_word", 32'(out_data), 32'hA000);
    wait_done(1'b0, 4, 1'b1);

    // Burst 2: address wrap
    apply_stimulus(12'hFFE, 13'd4);
    wait_done(1'b0, 4, 1'b1);

    // Burst 3: backpressure
    out_ready = 1'b0;
    apply_stimulus(12'h100, 13'd8);
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    check_output("stalled_issue_count", 32'(en_count), 32'd2);
    check_output("stalled_mem_en", {31'b0, mem_en}, 32'd0);
    check_output("stalled_valid", {31'b0, out_valid}, 32'd1);
    check_output("stalled_head", 32'(out_data), 32'(mem[12'h100]));
    wait_done(1'b1, 8, 1'b0);

    // Burst 4: zero length
    apply_stimulus(12'h020, 13'd0);
    check_output("len0_done", {31'b0, done}, 32'd1);
    check_output("len0_busy", {31'b0, busy}, 32'd0);
    check_output("len0_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge clock);
    #1;
    check_output("len0_done_clear", {31'b0, done}, 32'd0);
    check_output("len0_busy_after", {31'b0, busy}, 32'd0);
    check_output("len0_no_reads", 32'(en_count), 32'd0);

    // Burst 5: reset mid-burst, then a fresh burst
    hs_base = hs_count;
    apply_stimulus(12'h200, 13'd6);
    for (int n = 0; n < 50 && (hs_count - hs_base) < 3; n++) @(negedge clock);
    check_output("three_words_before_reset", 32'(hs_count - hs_base), 32'd3);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_done", {31'b0, done}, 32'd0);
    check_output("abort_mem_en", {31'b0, mem_en}, 32'd0);
    check_output("abort_mem_addr", 32'(mem_addr), 32'd0);
    check_output("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("abort_out_data", 32'(out_data), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      check_output("no_done_after_abort", {31'b0, done}, 32'd0);
    end
    apply_stimulus(12'h300, 13'd3);
    wait_done(1'b0, 3, 1'b1);

`ifdef MEM_BURST_READER_CHECKSUM_EN
    apply_stimulus(12'h400, 13'd3);
    wait_done(1'b0, 3, 1'b1);
    check_output("checksum_at_done", 32'(cs_at_done), 32'h1235);
    check_output("checksum_held", 32'(checksum), 32'h1235);
    apply_stimulus(12'h400, 13'd1);
    check_output("checksum_cleared", 32'(checksum), 32'd0);
    wait_done(1'b0, 1, 1'b1);
    check_output("checksum_single", 32'(cs_at_done), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
